// File: rtl/alu_core.sv
// 32-bit datapath ALU: combines Y-register operand A with bus operand B and
// registers the 64-bit {HI, LO} result for the Z register.
module alu_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     y_out,
  input  logic [WIDTH-1:0]     bus_mux_out,
  input  logic [3:0]           ALU_control,
  output logic [2*WIDTH-1:0]   z_in
);

  typedef enum logic [3:0] {
    OpAdd  = 4'b0000,
    OpSub  = 4'b0001,
    OpMul  = 4'b0010,
    OpDiv  = 4'b0011,
    OpShr  = 4'b0100,
    OpShra = 4'b0101,
    OpShl  = 4'b0110,
    OpRor  = 4'b0111,
    OpRol  = 4'b1000,
    OpAnd  = 4'b1001,
    OpOr   = 4'b1010,
    OpNeg  = 4'b1011,
    OpNot  = 4'b1100
  } op_e;

  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]          a;
  logic [WIDTH-1:0]          b;
  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]          quot;
  logic [WIDTH-1:0]          rem;
  logic                      div_zero;
  logic                      div_ovf;
  logic [WIDTH-1:0]          lo;
  logic [WIDTH-1:0]          hi;
  logic [2*WIDTH-1:0]        z_d;
  logic [2*WIDTH-1:0]        z_q;

  assign a = y_out;
  assign b = bus_mux_out;

  assign a_ext = $signed({{WIDTH{a[WIDTH-1]}}, a});
  assign b_ext = $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod  = a_ext * b_ext;

  assign div_zero = (b == '0);
  assign div_ovf  = (a == MinNeg) && (b == '1);

  // Divider corner cases are muxed out below, so the raw quotient/remainder
  // only need to be valid for ordinary operands.
  assign quot = $signed(a) / $signed(b);
  assign rem  = $signed(a) % $signed(b);

  always_comb begin
    lo = '0;
    hi = '0;
    case (op_e'(ALU_control))
      OpAdd:  lo = a + b;
      OpSub:  lo = a - b;
      OpMul:  {hi, lo} = prod;
      OpDiv: begin
        if (div_zero) begin
          lo = '1;
          hi = a;
        end else if (div_ovf) begin
          lo = MinNeg;
          hi = '0;
        end else begin
          lo = quot;
          hi = rem;
        end
      end
      OpShr:  lo = {1'b0, a[WIDTH-1:1]};
      OpShra: lo = {a[WIDTH-1], a[WIDTH-1:1]};
      OpShl:  lo = {a[WIDTH-2:0], 1'b0};
      OpRor:  lo = {a[0], a[WIDTH-1:1]};
      OpRol:  lo = {a[WIDTH-2:0], a[WIDTH-1]};
      OpAnd:  lo = a & b;
      OpOr:   lo = a | b;
      OpNeg:  lo = '0 - a;
      OpNot:  lo = ~a;
      default: begin
        lo = '0;
        hi = '0;
      end
    endcase
    z_d = {hi, lo};
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      z_q <= '0;
    end else begin
      z_q <= z_d;
    end
  end

  assign z_in = z_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core: reset behaviour, every opcode, divider
// corners and one-cycle latency across back-to-back opcode changes.
module tb_alu_core;

  logic        clk;
  logic        clear;
  logic [31:0] y_out;
  logic [31:0] bus_mux_out;
  logic [3:0]  alu_ctl;
  logic [63:0] z_in;

  int unsigned n_vec;
  int unsigned n_err;

  alu_core #(
    .WIDTH(32)
  ) u_dut (
    .clk         (clk),
    .clear       (clear),
    .y_out       (y_out),
    .bus_mux_out (bus_mux_out),
    .ALU_control (alu_ctl),
    .z_in        (z_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one vector just after an edge, clock it in, sample 1 time unit later.
  task automatic apply(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
    alu_ctl     = op;
    y_out       = a;
    bus_mux_out = b;
    @(posedge clk);
    #1;
    check(tag, z_in, exp);
  endtask

  // Expected results for A=4, B=2 across opcodes 0..12.
  logic [63:0] seq_exp [13];

  initial begin
    n_vec = 0;
    n_err = 0;
    seq_exp = '{64'd6, 64'd2, 64'd8, 64'd2, 64'd2, 64'd2, 64'd8, 64'd2, 64'd8,
                64'd0, 64'd6, 64'h0000_0000_FFFF_FFFC, 64'h0000_0000_FFFF_FFFB};

    clear       = 1'b0;
    y_out       = 32'h1234_5678;
    bus_mux_out = 32'h0000_0003;
    alu_ctl     = 4'b0010;
    #2;
    clear = 1'b1;
    #1;
    check("rst_async", z_in, 64'h0);
    @(posedge clk);
    #1;
    check("rst_hold", z_in, 64'h0);
    clear = 1'b0;

    apply("add_first", 4'b0000, 32'd4, 32'd2, 64'd6);
    apply("sub",       4'b0001, 32'd4, 32'd2, 64'd2);
    apply("mul",       4'b0010, 32'd4, 32'd2, 64'd8);
    apply("div",       4'b0011, 32'd4, 32'd2, 64'h0000_0000_0000_0002);
    apply("div_rem",   4'b0011, 32'd7, 32'd2, 64'h0000_0001_0000_0003);
    apply("div_neg",   4'b0011, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    apply("mul_neg",   4'b0010, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    apply("mul_big",   4'b0010, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    apply("shr",       4'b0100, 32'h8000_0001, 32'd7, 64'h0000_0000_4000_0000);
    apply("shra",      4'b0101, 32'h8000_0001, 32'd7, 64'h0000_0000_C000_0000);
    apply("shl",       4'b0110, 32'h8000_0001, 32'd7, 64'h0000_0000_0000_0002);
    apply("ror",       4'b0111, 32'h8000_0001, 32'd7, 64'h0000_0000_C000_0000);
    apply("rol",       4'b1000, 32'h8000_0001, 32'd7, 64'h0000_0000_0000_0003);
    apply("shr_4",     4'b0100, 32'd4, 32'd0, 64'd2);
    apply("and",       4'b1001, 32'd4, 32'd2, 64'd0);
    apply("or",        4'b1010, 32'd4, 32'd2, 64'd6);
    apply("neg",       4'b1011, 32'd4, 32'd2, 64'h0000_0000_FFFF_FFFC);
    apply("not",       4'b1100, 32'd4, 32'd2, 64'h0000_0000_FFFF_FFFB);
    apply("div_zero",  4'b0011, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF);
    apply("div_ovf",   4'b0011, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    apply("neg_min",   4'b1011, 32'h8000_0000, 32'd0, 64'h0000_0000_8000_0000);
    apply("add_wrap",  4'b0000, 32'hFFFF_FFFF, 32'd1, 64'h0);
    apply("sub_wrap",  4'b0001, 32'd0, 32'd1, 64'h0000_0000_FFFF_FFFF);
    apply("rsv_1101",  4'b1101, 32'd4, 32'd2, 64'h0);
    apply("rsv_1110",  4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0);
    apply("rsv_1111",  4'b1111, 32'd4, 32'd2, 64'h0);

    // Back-to-back opcodes: old value must persist until the edge, new one right after.
    y_out       = 32'd4;
    bus_mux_out = 32'd2;
    for (int i = 0; i < 13; i++) begin
      alu_ctl = 4'(i);
      #3;
      if (i > 0) check($sformatf("seq_hold%0d", i), z_in, seq_exp[i-1]);
      @(posedge clk);
      #1;
      check($sformatf("seq_op%0d", i), z_in, seq_exp[i]);
    end

    // Clear mid-sequence discards the pending result and restarts cleanly.
    alu_ctl = 4'b0000;
    #2;
    clear = 1'b1;
    #1;
    check("mid_clear", z_in, 64'h0);
    @(posedge clk);
    #1;
    check("mid_clear_hold", z_in, 64'h0);
    clear = 1'b0;
    #3;
    check("post_release", z_in, 64'h0);
    @(posedge clk);
    #1;
    check("resume", z_in, 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 32-bit integer ALU for the datapath.
- Operand A comes from the Y register (y_out); operand B comes from the bus multiplexer (bus_mux_out).
- It computes one of 13 operations selected by a 4-bit control code.
- It drives a registered 64-bit result toward the Z register (z_in): HI in [63:32], LO in [31:0].

Parameters:
- WIDTH, 32, operand width; result width is 2*WIDTH. Only 32 is required to be supported.

Ports:
- clk  input  1  system clock; rising-edge active
- clear  input  1  reset, asynchronous, active-high
- y_out  input  32  operand A (Y register contents)
- bus_mux_out  input  32  operand B (bus value)
- ALU_control  input  4  operation select
- z_in  output  64  registered result; [63:32] HI, [31:0] LO

Behaviour:
- Registered output.
  - z_in is loaded every rising clk edge with f(A, B, ALU_control) from that edge.
  - Latency is 1 cycle; there is no enable or handshake.
  - The function f is purely combinational, with no internal state beyond the z_in register.
- Reset.
  - clear=1 forces z_in to 64'h0 immediately, regardless of clk.
  - z_in holds 0 while clear=1.
  - The first load occurs on the first rising edge after clear is deasserted.
  - If clear is asserted mid-sequence, the pending result is discarded.
- Opcodes (A=y_out, B=bus_mux_out). Unless stated otherwise, the result is in LO and HI=0.
  - 0000 ADD: A+B mod 2^32; carry discarded.
  - 0001 SUB: A-B mod 2^32.
  - 0010 MUL: signed 32x32 -> full 64-bit two's-complement product in [63:0].
  - 0011 DIV: signed divide with truncation toward zero. LO=quotient, HI=remainder; the remainder takes the sign of the dividend.
    - B=0: LO=32'hFFFFFFFF, HI=A.
    - A=32'h80000000, B=32'hFFFFFFFF: LO=32'h80000000, HI=0.
  - 0100 SHR: logical right shift of A by 1, MSB filled with 0. B is ignored.
  - 0101 SHRA: arithmetic right shift of A by 1; A[31] is replicated.
  - 0110 SHL: left shift of A by 1, LSB filled with 0.
  - 0111 ROR: rotate A right by 1 ({A[0],A[31:1]}).
  - 1000 ROL: rotate A left by 1 ({A[30:0],A[31]}).
  - 1001 AND: A & B.
  - 1010 OR: A | B.
  - 1011 NEG: two's-complement negate (0-A) mod 2^32. NEG(32'h80000000)=32'h80000000.
  - 1100 NOT: bitwise ~A. This is bitwise, not logical.
  - 1101, 1110, 1111: reserved; result is 64'h0.
- Inputs may change at any time; only values at the rising edge matter.
- Back-to-back opcode changes each cycle are fully supported; there are no hazards.

Test Plan:
- Reset: drive clear=1 with non-zero inputs -> z_in=0 asynchronously, before any clk edge. Release clear, A=4, B=2, op 0000 -> after 1 edge z_in=64'd6.
- Arithmetic with A=4, B=2:
  - SUB -> 2
  - MUL -> 8
  - DIV -> LO=2, HI=0
  - A=7, B=2 DIV -> LO=3, HI=1
  - A=-7, B=2 DIV -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF
  - A=-3, B=5 MUL -> 64'hFFFFFFFFFFFFFFF1
- Shifts/rotates with A=32'h80000001:
  - SHR -> 32'h40000000
  - SHRA -> 32'hC0000000
  - SHL -> 32'h00000002
  - ROR -> 32'hC0000000
  - ROL -> 32'h00000003
  - A=4 SHR -> 2
  - HI=0 in all cases.
- Logic with A=4, B=2:
  - AND -> 0
  - OR -> 6
  - NEG -> LO=32'hFFFFFFFC, HI=0
  - NOT -> LO=32'hFFFFFFFB
- Corners:
  - B=0 DIV with A=9 -> LO=32'hFFFFFFFF, HI=9
  - ADD 32'hFFFFFFFF+1 -> 0
  - reserved op 1111 -> 0
- Timing: change opcode every cycle through all 13 codes -> each z_in value appears exactly one edge after its inputs. Assert clear mid-sequence -> z_in=0 at once, resuming 1 edge after release.
